// File: rtl/unary_add_sched.sv
// unary_add_sched: round-robin scheduler sharing one serial unary adder between
// NREQ requesters. Each transaction runs READ (READ_LEN cycles), TURN (1),
// WRITE (8) and FLUSH (1). The unary result is streamed back to the granted
// requester, and a sticky overflow flag is returned with the last result bit.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req, a_in, b_in     per-requester request and serial operands
//   gnt                 one-hot grant, held for the whole transaction
//   add_en, add_rw      adder enable / read_or_write (0 read, 1 write)
//   add_a, add_b        adder operand pulses (granted requester only)
//   add_dout, add_c     adder serial result and registered carry
//   res_valid/bit/last  result stream; res_ovf valid with res_last
//   busy                high whenever the scheduler is not idle
//
// Build option: define UNARY_SCHED_FIXED_PRIO_EN for fixed priority (lowest
// requesting index wins) instead of round-robin.
module unary_add_sched #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned READ_LEN = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] a_in,
    input  logic [NREQ-1:0] b_in,
    output logic [NREQ-1:0] gnt,
    output logic            add_en,
    output logic            add_rw,
    output logic            add_a,
    output logic            add_b,
    input  logic            add_dout,
    input  logic            add_c,
    output logic            res_valid,
    output logic            res_bit,
    output logic            res_last,
    output logic            res_ovf,
    output logic            busy
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] READ_LAST  = CW'(READ_LEN - 1);
    localparam logic [CW-1:0] WRITE_LAST = CW'(7);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        TURN,
        WRITE,
        FLUSH
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [IW-1:0] idx, idx_d;
    logic          ovf_r, ovf_d;
    logic          any_req;
    logic [IW-1:0] win;

`ifdef UNARY_SCHED_FIXED_PRIO_EN
    // Fixed priority: scan downwards so the lowest requesting index wins.
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                any_req = 1'b1;
                win     = IW'(i);
            end
        end
    end
`else
    logic [IW-1:0] ptr;
    int            rr_j;

    // Round-robin: scan offsets downwards so the smallest offset from ptr wins.
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        rr_j    = 0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            rr_j = (int'(ptr) + i) % int'(NREQ);
            if (req[rr_j]) begin
                any_req = 1'b1;
                win     = IW'(rr_j);
            end
        end
    end

    // Pointer moves just past the winner on every grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (state == IDLE && any_req) begin
            ptr <= (win == IW'(NREQ - 1)) ? '0 : IW'(win + IW'(1));
        end
    end
`endif

    // Next-state, phase counter, winner capture and overflow accumulation.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        ovf_d   = ovf_r;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_d = READ;
                    cnt_d   = '0;
                    idx_d   = win;
                    ovf_d   = 1'b0;
                end
            end
            READ: begin
                // Carry lags the add by one cycle, so skip the first read cycle.
                if (cnt != '0) begin
                    ovf_d = ovf_r | add_c;
                end
                if (cnt == READ_LAST) begin
                    state_d = TURN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = CW'(cnt + CW'(1));
                end
            end
            TURN: begin
                ovf_d   = ovf_r | add_c;
                state_d = WRITE;
                cnt_d   = '0;
            end
            WRITE: begin
                if (cnt == WRITE_LAST) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = CW'(cnt + CW'(1));
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register plus outputs registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            ovf_r     <= 1'b0;
            gnt       <= '0;
            add_en    <= 1'b0;
            add_rw    <= 1'b0;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            res_ovf   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            idx       <= idx_d;
            ovf_r     <= ovf_d;
            gnt       <= (state_d != IDLE) ? (NREQ'(1) << idx_d) : '0;
            add_en    <= (state_d == READ) || (state_d == WRITE);
            add_rw    <= (state_d == WRITE);
            // The first WRITE cycle only loads the adder's dout register.
            res_valid <= ((state_d == WRITE) && (cnt_d != '0)) || (state_d == FLUSH);
            res_last  <= (state_d == FLUSH);
            res_ovf   <= (state_d == FLUSH) && ovf_d;
            busy      <= (state_d != IDLE);
        end
    end

    // Operand mux from the registered index; other requesters never reach the adder.
    assign add_a   = (state == READ) ? a_in[idx] : 1'b0;
    assign add_b   = (state == READ) ? b_in[idx] : 1'b0;
    assign res_bit = res_valid & add_dout;

endmodule

// File: tb/tb_unary_add_sched.sv
// Testbench for unary_add_sched with a behavioural unary adder attached.
module tb_unary_add_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, a_in, b_in;
    logic [3:0] gnt;
    logic       add_en, add_rw, add_a, add_b, add_dout, add_c;
    logic       res_valid, res_bit, res_last, res_ovf, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    unary_add_sched #(.NREQ(4), .READ_LEN(7)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
        .add_en(add_en), .add_rw(add_rw), .add_a(add_a), .add_b(add_b),
        .add_dout(add_dout), .add_c(add_c), .res_valid(res_valid),
        .res_bit(res_bit), .res_last(res_last), .res_ovf(res_ovf), .busy(busy)
    );

    // Unary adder: 3-bit count, carry and dout registered, reset with the scheduler.
    logic [2:0] acnt;
    always @(posedge clk) begin
        if (rst) begin
            acnt     <= 3'd0;
            add_c    <= 1'b0;
            add_dout <= 1'b0;
        end else if (add_en && !add_rw) begin
            {add_c, acnt} <= {1'b0, acnt} + 4'(add_a) + 4'(add_b);
        end else if (add_en && add_rw) begin
            add_dout <= (acnt != 3'd0);
            if (acnt != 3'd0) acnt <= acnt - 3'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, " gnt"},       32'(gnt),       32'h0);
        check({tag, " add_en"},    32'(add_en),    32'h0);
        check({tag, " add_rw"},    32'(add_rw),    32'h0);
        check({tag, " add_a"},     32'(add_a),     32'h0);
        check({tag, " add_b"},     32'(add_b),     32'h0);
        check({tag, " res_valid"}, 32'(res_valid), 32'h0);
        check({tag, " res_bit"},   32'(res_bit),   32'h0);
        check({tag, " res_last"},  32'(res_last),  32'h0);
        check({tag, " res_ovf"},   32'(res_ovf),   32'h0);
        check({tag, " busy"},      32'(busy),      32'h0);
    endtask

    // One transaction from IDLE; other requesters' operands toggle as noise.
    task automatic run_txn(input string tag, input int r, input logic [6:0] as,
                           input logic [6:0] bs, input int n_ones,
                           input logic ovf_exp, input bit drop);
        int         t0;
        int         nv;
        bit         done;
        logic [7:0] bits;
        logic [7:0] exp_bits;
        t0       = cyc;
        req      = 4'(1 << r);
        tick();
        check({tag, " gnt"},    32'(gnt),    32'(1 << r));
        check({tag, " add_en"}, 32'(add_en), 32'h1);
        check({tag, " busy"},   32'(busy),   32'h1);
        for (int k = 0; k < 7; k++) begin
            a_in    = (k % 2 == 1) ? 4'hF : 4'h0;
            b_in    = (k % 2 == 1) ? 4'h0 : 4'hF;
            a_in[r] = as[k];
            b_in[r] = bs[k];
            if (drop && k == 2) req = 4'h0;
            #1;
            check({tag, " add_a"}, 32'(add_a), 32'(as[k]));
            check({tag, " add_b"}, 32'(add_b), 32'(bs[k]));
            tick();
        end
        req  = 4'h0;
        a_in = 4'h0;
        b_in = 4'h0;
        check({tag, " turn_en"}, 32'(add_en), 32'h0);
        nv   = 0;
        bits = 8'h0;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            tick();
            if (res_valid) begin
                if (nv < 8) bits[nv] = res_bit;
                nv++;
            end
            if (res_last) begin
                done = 1'b1;
                check({tag, " ovf"},     32'(res_ovf), 32'(ovf_exp));
                check({tag, " latency"}, 32'(cyc - t0), 32'd17);
                check({tag, " gnt_held"}, 32'(gnt),    32'(1 << r));
            end
        end
        exp_bits = 8'((1 << n_ones) - 1);
        check({tag, " last_seen"}, 32'(done), 32'h1);
        check({tag, " nvalid"},    32'(nv),   32'd8);
        check({tag, " bits"},      32'(bits), 32'(exp_bits));
        tick();
        check({tag, " gnt_drop"},  32'(gnt),  32'h0);
        check({tag, " idle"},      32'(busy), 32'h0);
    endtask

    initial begin
        int  prev;
        int  exp_idx;
        bit  seen;
        rst  = 1'b1;
        req  = 4'h0;
        a_in = 4'h0;
        b_in = 4'h0;
        repeat (3) tick();
        reset_checks("reset");
        rst = 1'b0;
        tick();

        // All four requesting: grants rotate, 18 cycles apart.
        req  = 4'hF;
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            seen = 1'b0;
            for (int w = 0; w < 40 && gnt != 4'h0; w++) tick();
            for (int w = 0; w < 40 && !seen; w++) begin
                if (gnt != 4'h0) seen = 1'b1;
                else tick();
            end
            check("rr grant_seen", 32'(seen), 32'h1);
`ifdef UNARY_SCHED_FIXED_PRIO_EN
            exp_idx = 0;
`else
            exp_idx = g % 4;
`endif
            check("rr grant", 32'(gnt), 32'(1 << exp_idx));
            if (g > 0) check("rr spacing", 32'(cyc - prev), 32'd18);
            prev = cyc;
        end
        req  = 4'h0;
        seen = 1'b0;
        for (int w = 0; w < 40 && !seen; w++) begin
            if (!busy) seen = 1'b1;
            else tick();
        end
        check("rr drain", 32'(seen), 32'h1);

        run_txn("sum5",  0, 7'b0000111, 7'b0000011, 5, 1'b0, 1'b0);
        run_txn("sum14", 0, 7'b1111111, 7'b1111111, 6, 1'b1, 1'b0);
        run_txn("sum8",  0, 7'b1111111, 7'b0000001, 0, 1'b1, 1'b0);

        // Reset on WRITE cycle 4 aborts the transaction and clears the adder.
        req  = 4'h1;
        a_in = 4'h1;
        b_in = 4'h1;
        seen = 1'b0;
        for (int w = 0; w < 30 && !seen; w++) begin
            tick();
            if (add_rw) seen = 1'b1;
        end
        check("abort reach_write", 32'(seen), 32'h1);
        req  = 4'h0;
        a_in = 4'h0;
        b_in = 4'h0;
        repeat (3) tick();
        check("abort write4", 32'(add_rw), 32'h1);
        rst = 1'b1;
        tick();
        reset_checks("abort");
        rst = 1'b0;
        run_txn("post_rst", 0, 7'b0000111, 7'b0000011, 5, 1'b0, 1'b0);

        // Requester 2 drops req mid-READ; requester 1 operands toggle as noise.
        run_txn("drop2", 2, 7'b1010101, 7'b0000110, 6, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
